// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : imm_ext_pkg
// Brief    : Shared types and constants for the immediate-extension pipe:
//            extension mode encoding and the handshake-storage state set.
// Revision : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

  // Width of the extension mode field carried on the input bus
  localparam int c_mode_w = 2;

  // Extension modes; encodings match the raw in_mode field values
  typedef enum logic [c_mode_w-1:0] {
    MODE_SEXT      = 2'b00,
    MODE_ZEXT      = 2'b01,
    MODE_SEXT_SHL2 = 2'b10,
    MODE_UPPER     = 2'b11
  } imm_mode_e;

  // Occupancy of the output stage + skid entry pair
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,  // nothing held
    SKID_BUSY  = 2'b01,  // output stage holds a result, skid free
    SKID_FULL  = 2'b10   // output stage and skid entry both hold results
  } skid_state_e;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface: imm_extend_pipe_if
// Brief    : Operand/result handshake bus of the immediate-extension pipe.
//            master = operand producer / result consumer, slave = the pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);

  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic [c_mode_w-1:0] in_mode;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic [TAG_W-1:0]    out_tag;
  logic [CNT_W-1:0]    conv_count;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, conv_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, conv_count
  );

endinterface : imm_extend_pipe_if
`default_nettype wire

// File: rtl/imm_extend_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer
// Brief    : Two-entry handshake store (output stage + one skid entry) with a
//            registered in_ready, so out_ready never reaches in_ready through
//            logic. Full throughput when the consumer is always ready.
// Revision : 1.0 - initial release
// ============================================================================
module skid_buffer
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       r_state;
  skid_state_e       w_state_next;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_out;
  logic              w_promote_skid;
  logic              w_load_skid;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != SKID_EMPTY);
  assign out_data  = r_out_data;

  // State register plus registered ready; ready stays low during reset and
  // rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SKID_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != SKID_FULL);
    end
  end

  // Next-state and load-enable decode
  always_comb begin
    w_state_next   = r_state;
    w_load_out     = 1'b0;
    w_promote_skid = 1'b0;
    w_load_skid    = 1'b0;
    case (r_state)
      SKID_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = SKID_BUSY;
          w_load_out   = 1'b1;
        end
      end
      SKID_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          // Replace the departing result directly: no bubble
          w_load_out = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = SKID_FULL;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only the drain path can fire
        if (w_out_fire) begin
          w_state_next   = SKID_BUSY;
          w_promote_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = SKID_EMPTY;
      end
    endcase
  end

  // Data storage; the output stage only changes on a load, so a held
  // result stays stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_out) begin
        r_out_data <= in_data;
      end else if (w_promote_skid) begin
        r_out_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
      end
    end
  end

endmodule : skid_buffer
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : Immediate extender (SEXT / ZEXT / SEXT<<2 / UPPER) with a
//            one-cycle, two-entry skid-buffered output and a counter of
//            consumed results. The tag travels alongside each result.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_extend_pipe_if.slave bus
);

  localparam int c_store_w = OUT_W + TAG_W;

  // Reject unsupported widths at elaboration
  generate
    if (OUT_W < IN_W) begin : g_bad_out_w
      $error("imm_extend_pipe: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    end
    if ((IN_W < 2) || (IN_W > 32)) begin : g_bad_in_w
      $error("imm_extend_pipe: IN_W (%0d) must be within 2..32", IN_W);
    end
  endgenerate

  imm_mode_e              w_mode;
  logic signed [IN_W-1:0] w_in_signed;
  logic [OUT_W-1:0]       w_sext;
  logic [OUT_W-1:0]       w_zext;
  logic [OUT_W-1:0]       w_ext;
  logic [c_store_w-1:0]   w_store_in;
  logic [c_store_w-1:0]   w_store_out;
  logic                   w_out_fire;
  logic [CNT_W-1:0]       r_conv_count;

  assign w_mode      = imm_mode_e'(bus.in_mode);
  assign w_in_signed = $signed(bus.in_data);
  // A size cast of a signed operand replicates its MSB
  assign w_sext      = OUT_W'(w_in_signed);
  assign w_zext      = OUT_W'(bus.in_data);

  // Mode selection happens before storage, so a later in_mode change can
  // never alter a result that is already held
  always_comb begin
    w_ext = w_sext;
    case (w_mode)
      MODE_SEXT:      w_ext = w_sext;
      MODE_ZEXT:      w_ext = w_zext;
      MODE_SEXT_SHL2: w_ext = w_sext << 2;
      MODE_UPPER:     w_ext = w_zext << IN_W;
      default:        w_ext = w_sext;
    endcase
  end

  assign w_store_in = {w_ext, bus.in_tag};

  skid_buffer #(
    .DATA_W (c_store_w)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (w_store_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_store_out)
  );

  assign bus.out_data = w_store_out[TAG_W +: OUT_W];
  assign bus.out_tag  = w_store_out[TAG_W-1:0];

  assign w_out_fire = bus.out_valid && bus.out_ready;

  // Count consumed results; wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_count <= '0;
    end else if (w_out_fire) begin
      r_conv_count <= r_conv_count + CNT_W'(1);
    end
  end

  assign bus.conv_count = r_conv_count;

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Self-checking bench: two pipe instances (32/16-bit and a narrow
//            12/8-bit one with a 4-bit counter) compared every cycle against a
//            FIFO-occupancy reference model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  localparam int A_IN_W = 16, A_OUT_W = 32, A_TAG_W = 4, A_CNT_W = 16;
  localparam int B_IN_W = 8,  B_OUT_W = 12, B_TAG_W = 4, B_CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .TAG_W(A_TAG_W), .CNT_W(A_CNT_W)) bus_a ();
  imm_extend_pipe_if #(.IN_W(B_IN_W), .OUT_W(B_OUT_W), .TAG_W(B_TAG_W), .CNT_W(B_CNT_W)) bus_b ();

  imm_extend_pipe #(.IN_W(A_IN_W), .OUT_W(A_OUT_W), .TAG_W(A_TAG_W), .CNT_W(A_CNT_W)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  imm_extend_pipe #(.IN_W(B_IN_W), .OUT_W(B_OUT_W), .TAG_W(B_TAG_W), .CNT_W(B_CNT_W)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension computed with plain masks and arithmetic
  function automatic logic [63:0] ext_model(input int in_w, input int out_w,
                                            input logic [31:0] d, input logic [1:0] m);
    logic [63:0] mask_in, mask_out, z, s, r;
    mask_in  = (64'd1 << in_w) - 64'd1;
    mask_out = (64'd1 << out_w) - 64'd1;
    z = {32'd0, d} & mask_in;
    s = d[in_w-1] ? (z | ~mask_in) : z;
    case (m)
      2'd0:    r = s;
      2'd1:    r = z;
      2'd2:    r = s * 64'd4;
      default: r = z << in_w;
    endcase
    return r & mask_out;
  endfunction

  // Ready is expected from the first edge after reset release onward
  logic armed;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Model: each instance is a 2-deep FIFO of {tag,result}
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int  cnt_a = 0, cnt_b = 0;
  int  a_outs = 0, b_outs = 0;
  bit  a_acc = 0, b_acc = 0;

  // Compare process: sampled on the falling edge, mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("a_rst_out_valid", bus_a.out_valid, 0);
      chk("a_rst_in_ready", bus_a.in_ready, 0);
      chk("a_rst_out_data", {bus_a.out_tag, bus_a.out_data}, 0);
      chk("a_rst_count", bus_a.conv_count, 0);
      chk("b_rst_out_valid", bus_b.out_valid, 0);
      chk("b_rst_in_ready", bus_b.in_ready, 0);
      chk("b_rst_out_data", {bus_b.out_tag, bus_b.out_data}, 0);
      chk("b_rst_count", bus_b.conv_count, 0);
      qa.delete(); qb.delete();
      cnt_a = 0; cnt_b = 0; a_acc = 0; b_acc = 0;
    end else begin
      // instance A
      chk("a_out_valid", bus_a.out_valid, (qa.size() != 0));
      chk("a_in_ready", bus_a.in_ready, (armed && qa.size() < 2));
      if (bus_a.out_valid && qa.size() != 0)
        chk("a_out_data_tag", {bus_a.out_tag, bus_a.out_data}, qa[0]);
      chk("a_conv_count", bus_a.conv_count, cnt_a);
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (qa.size() != 0) void'(qa.pop_front());
        cnt_a = (cnt_a + 1) % (1 << A_CNT_W);
        a_outs++;
      end
      a_acc = bus_a.in_valid && bus_a.in_ready;
      if (a_acc)
        qa.push_back((64'(bus_a.in_tag) << A_OUT_W) |
                     ext_model(A_IN_W, A_OUT_W, 32'(bus_a.in_data), bus_a.in_mode));
      // instance B
      chk("b_out_valid", bus_b.out_valid, (qb.size() != 0));
      chk("b_in_ready", bus_b.in_ready, (armed && qb.size() < 2));
      if (bus_b.out_valid && qb.size() != 0)
        chk("b_out_data_tag", {bus_b.out_tag, bus_b.out_data}, qb[0]);
      chk("b_conv_count", bus_b.conv_count, cnt_b);
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (qb.size() != 0) void'(qb.pop_front());
        cnt_b = (cnt_b + 1) % (1 << B_CNT_W);
        b_outs++;
      end
      b_acc = bus_b.in_valid && bus_b.in_ready;
      if (b_acc)
        qb.push_back((64'(bus_b.in_tag) << B_OUT_W) |
                     ext_model(B_IN_W, B_OUT_W, 32'(bus_b.in_data), bus_b.in_mode));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [15:0] d, input logic [1:0] m, input logic [3:0] t);
    bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_mode = m; bus_a.in_tag = t;
  endtask

  task automatic set_a_rand();
    set_a(16'($urandom), 2'($urandom), 4'($urandom));
  endtask

  // One operand with the consumer ready; result must be visible one edge later
  task automatic send_a(input logic [15:0] d, input logic [1:0] m, input logic [3:0] t,
                        input logic [31:0] expv, input string nm);
    set_a(d, m, t);
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = ~d;
    bus_a.in_mode  = ~m;
    chk({nm, "_valid"}, bus_a.out_valid, 1);
    chk({nm, "_data"}, bus_a.out_data, expv);
    chk({nm, "_tag"}, bus_a.out_tag, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, stalls, outs0;
    bus_a.in_valid = 0; bus_a.in_data = 0; bus_a.in_mode = 0; bus_a.in_tag = 0; bus_a.out_ready = 1;
    bus_b.in_valid = 0; bus_b.in_data = 0; bus_b.in_mode = 0; bus_b.in_tag = 0; bus_b.out_ready = 1;

    // Model pins against hand-computed values
    chk("pin_sext", ext_model(16, 32, 32'h8001, 2'd0), 64'hFFFF8001);
    chk("pin_zext", ext_model(16, 32, 32'h8001, 2'd1), 64'h00008001);
    chk("pin_shl2", ext_model(16, 32, 32'hFFFF, 2'd2), 64'hFFFFFFFC);
    chk("pin_upper", ext_model(8, 12, 32'hAB, 2'd3), 64'hB00);

    // Reset and release between edges
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("ready_before_edge", bus_a.in_ready, 0);
    tick();
    chk("ready_after_edge_a", bus_a.in_ready, 1);
    chk("ready_after_edge_b", bus_b.in_ready, 1);

    // Literal conversions, one cycle latency
    send_a(16'h8001, 2'd0, 4'h1, 32'hFFFF8001, "sext");
    send_a(16'h8001, 2'd1, 4'h2, 32'h00008001, "zext");
    send_a(16'hFFFF, 2'd2, 4'h3, 32'hFFFFFFFC, "shl2");
    send_a(16'h1234, 2'd3, 4'h4, 32'h12340000, "upper");
    tick();

    // Stalled consumer: only two of three operands accepted, held data stable
    bus_a.out_ready = 1'b0;
    k = 0;
    outs0 = a_outs;
    set_a(16'(k + 1), 2'd0, 4'(k + 1));
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (a_acc) begin
        k++;
        if (k == 2) chk("stall_ready_low", bus_a.in_ready, 0);
        if (k < 3) set_a(16'(k + 1), 2'd0, 4'(k + 1));
        else bus_a.in_valid = 1'b0;
      end
      chk("stall_hold_data", bus_a.out_data, 32'h1);
    end
    chk("stall_accepted", k, 2);
    bus_a.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && (a_outs - outs0) < 3; cyc++) begin
      tick();
      if (a_acc) begin
        k++;
        if (k < 3) set_a(16'(k + 1), 2'd0, 4'(k + 1));
        else bus_a.in_valid = 1'b0;
      end
    end
    chk("release_emitted", a_outs - outs0, 3);
    bus_a.in_valid = 1'b0;
    tick();

    // Fill both entries, then reset asynchronously mid-cycle
    bus_a.out_ready = 1'b0;
    n = 0;
    set_a_rand();
    for (int cyc = 0; cyc < 10 && n < 2; cyc++) begin
      tick();
      if (a_acc) begin n++; set_a_rand(); end
    end
    bus_a.in_valid = 1'b0;
    chk("full_ready_low", bus_a.in_ready, 0);
    chk("full_out_valid", bus_a.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus_a.out_valid, 0);
    chk("async_rst_in_ready", bus_a.in_ready, 0);
    chk("async_rst_count", bus_a.conv_count, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    bus_a.out_ready = 1'b1;
    repeat (3) tick();
    chk("no_stale_after_rst", bus_a.out_valid, 0);

    // Narrow instance: truncated UPPER then counter wrap after 17 transfers
    n = 0;
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'hAB; bus_b.in_mode = 2'd3; bus_b.in_tag = 4'h5;
    tick();
    chk("b_upper_trunc", bus_b.out_data, 12'hB00);
    for (int cyc = 0; cyc < 60 && n < 17; cyc++) begin
      if (b_acc) n++;
      if (n < 17) begin
        bus_b.in_data = 8'($urandom); bus_b.in_mode = 2'($urandom); bus_b.in_tag = 4'($urandom);
      end else begin
        bus_b.in_valid = 1'b0;
      end
      if (n < 17) tick();
    end
    bus_b.in_valid = 1'b0;
    repeat (3) tick();
    chk("b_count_wrap", bus_b.conv_count, 1);

    // Back-to-back stream of 100 operands
    n = 0; stalls = 0;
    set_a_rand();
    for (int cyc = 0; cyc < 150 && n < 100; cyc++) begin
      tick();
      if (a_acc) n++; else stalls++;
      if (n < 100) set_a_rand(); else bus_a.in_valid = 1'b0;
    end
    bus_a.in_valid = 1'b0;
    chk("b2b_accepted", n, 100);
    chk("b2b_no_stall", stalls, 0);
    repeat (3) tick();
    chk("b2b_count", bus_a.conv_count, 100);

    // Random traffic on both instances
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus_a.in_valid  = 1'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      bus_a.in_data = 16'($urandom); bus_a.in_mode = 2'($urandom); bus_a.in_tag = 4'($urandom);
      bus_b.in_valid  = 1'($urandom);
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      bus_b.in_data = 8'($urandom); bus_b.in_mode = 2'($urandom); bus_b.in_tag = 4'($urandom);
      tick();
    end

    // Drain
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_a_empty", bus_a.out_valid, 0);
    chk("drain_b_empty", bus_b.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_imm_extend_pipe
`default_nettype wire

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width (2..32) SHALL be supported.
REQ-002 Parameter OUT_W, default 32, result width; OUT_W >= IN_W SHALL hold (elaboration error otherwise).
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried with each operand.
REQ-004 Parameter CNT_W, default 16, width of the completed-conversion counter.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operand offered.
REQ-008 in_ready  output  1  block can accept operand this cycle.
REQ-009 in_data  input  IN_W  raw immediate.
REQ-010 in_mode  input  2  extension mode (see REQ-016).
REQ-011 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  OUT_W  extended result.
REQ-015 out_tag  output  TAG_W  tag of out_data; conv_count  output  CNT_W  number of results consumed.

Function
REQ-016 Modes: 00 SEXT = replicate in_data[IN_W-1] into upper OUT_W-IN_W bits; 01 ZEXT = zero upper bits; 10 SEXT_SHL2 = SEXT result shifted left 2, low 2 bits zero, upper bits truncated to OUT_W; 11 UPPER = zero-extended in_data shifted left by IN_W, truncated to OUT_W.
REQ-017 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 Latency SHALL be exactly 1 cycle: an operand accepted at edge N appears on out_data/out_tag with out_valid=1 after edge N when the output stage is free.
REQ-019 Output stage plus one skid entry (2 entries total); sustained throughput 1 result/cycle when out_ready=1.
REQ-020 in_ready SHALL be a registered signal, equal to NOT(skid entry occupied); no combinational path out_ready -> in_ready.
REQ-021 Operand accepted while output stage held (out_valid && !out_ready) SHALL go to skid entry; in_ready drops next cycle.
REQ-022 When output drains with skid full, skid contents move to output stage next edge, in_ready returns to 1 same edge.
REQ-023 Simultaneous in/out transfer with skid empty: new result replaces output stage, no bubble.
REQ-024 out_data/out_tag SHALL be stable while out_valid && !out_ready; results SHALL leave in acceptance order; none lost or duplicated.
REQ-025 conv_count SHALL increment by 1 per out transfer, wrap 2^CNT_W-1 -> 0.
REQ-026 Mode is computed at input acceptance; in_mode changes after acceptance SHALL not affect held results.

Reset
REQ-027 While rst_n=0: out_valid=0, in_ready=0, out_data=0, out_tag=0, conv_count=0, skid empty.
REQ-028 in_ready SHALL become 1 on first clk edge after rst_n deasserts.
REQ-029 Reset mid-operation SHALL discard both entries immediately (asynchronous); no result emitted afterward.

Structure
REQ-030 Package imm_ext_pkg SHALL hold mode enum (MODE_SEXT, MODE_ZEXT, MODE_SEXT_SHL2, MODE_UPPER) and the mode field width constant.
REQ-031 Handshake storage SHALL be one sub-module skid_buffer (parametrised data width = OUT_W+TAG_W); extension logic is combinational in front of it.

Verification
REQ-032 IN_W=16, OUT_W=32: SEXT 0x8001 -> 0xFFFF8001; ZEXT 0x8001 -> 0x00008001; SEXT_SHL2 0xFFFF -> 0xFFFFFFFC; UPPER 0x1234 -> 0x12340000, each 1 cycle after acceptance.
REQ-033 out_ready=0 for 4 cycles, stream 3 operands: 2 accepted, in_ready=0 from the cycle after 2nd accept, held out_data stable; release -> all 3 emitted in order, no loss.
REQ-034 Continuous in_valid=out_ready=1 for 100 random operands -> 100 results back-to-back, conv_count=100, tags match.
REQ-035 rst_n pulsed low with both entries full -> out_valid=0 and in_ready=0 immediately, conv_count=0, no stale result after release.
REQ-036 CNT_W=4: 17 transfers -> conv_count=1 (wrap verified); IN_W=8, OUT_W=12 UPPER 0xAB -> 0xB00 (truncation).
